unidade_controle: RTL and testbench
===================================

# unidade_controle

Main FSM of the MindFocus game. It sequences the game datapath (`fluxo_dados`) through the round loop: clear, index generation, image display, wait for a play, register, compare, score, advance round. It sits beside `fluxo_dados` in the top level and drives all of its `zera*`, `registra*` and `conta*` inputs from the datapath status flags. It adds an internal play-timeout timer that the datapath does not provide.

## Interface
- `T_JOGADA`, default 10000: cycles allowed for a play before timeout; must be ≥ 2.
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `iniciar` input 1: start request, level-sampled.
- `jogada_feita` input 1: one-cycle play pulse from the datapath edge detector.
- `botaoIgualMemoria` input 1: comparator result for the registered play.
- `rodadaIgualFinal` input 1: round counter equals final round (3).
- `indiceReady` input 1: index generator has a valid permutation.
- `timeout_img` input 1: image-display counter reached its end.
- `zeraA`, `zeraRod`, `zeraR`, `zeraM`, `zeraI`, `zeraContImg` output 1 each: datapath clears.
- `registraR`, `registraM` output 1 each: register enables for the play register and the index register.
- `contaRod`, `contaA`, `contaI`, `contaimg` output 1 each: counter enables.
- `pronto` output 1: game finished.
- `timeout_jogada` output 1: one-cycle pulse when a play timed out.
- `db_estado` output 4: current state code.

## Operation
- The FSM uses a registered state. Outputs are decoded combinationally from the state. `contaA` is the only Mealy output and is gated by `botaoIgualMemoria`.
- Any output not listed for a state is 0.
- States (code, outputs, transitions):
  - 0 `inicial`: no outputs. If `iniciar` = 1 → 1.
  - 1 `preparacao`: `zeraA`, `zeraRod`, `zeraR`, `zeraM`, `zeraI`, `zeraContImg` = 1. → 2 unconditionally.
  - 2 `espera_indice`: no outputs. If `indiceReady` = 1 → 3; otherwise stay.
  - 3 `registra_indice`: `registraM` = 1, `zeraContImg` = 1. → 4.
  - 4 `mostra_imagem`: `contaimg` = 1. If `timeout_img` = 1 → 5; otherwise stay.
  - 5 `inicia_jogada`: `zeraI` = 1, `zeraR` = 1. The internal timer is cleared to 0. → 6.
  - 6 `espera_jogada`: `contaI` = 1 and the timer increments.
    - If `jogada_feita` = 1 → 7.
    - Else if timer = `T_JOGADA`-1 → 9.
    - Otherwise stay.
  - 7 `registra_jogada`: `registraR` = 1. → 8.
  - 8 `compara`: `contaA` = `botaoIgualMemoria`. → 10.
  - 9 `estouro`: `timeout_jogada` = 1. No score. → 10.
  - 10 `proxima_rodada`: `contaRod` = 1. → 11.
  - 11 `verifica_fim`: evaluates `rodadaIgualFinal`, which already reflects the increment from state 10. If 1 → 12; otherwise → 2.
  - 12 `fim`: `pronto` = 1. If `iniciar` = 1 → 1; otherwise stay.
- Unused codes 13–15 → 0 on the next clock, with no outputs asserted.
- Play timer:
  - Width is `$clog2(T_JOGADA)`.
  - Cleared in state 5.
  - Increments only in state 6.
  - Holds its value elsewhere.
  - Never wraps, because exit from state 6 occurs at `T_JOGADA`-1.
- `jogada_feita` is ignored outside state 6. Presses during the image display are not counted.
- `iniciar` is ignored outside states 0 and 12.

## Timing
- Reset (`reset` = 0):
  - Immediate, asynchronous return to `inicial`.
  - Timer cleared to 0.
  - All outputs 0, `db_estado` = 0.
  - Applies mid-round as well; no partial pulses follow release.
  - Release is synchronised by the system; the first transition happens on the first rising edge with `reset` = 1.
- Start latency: `iniciar` sampled high in state 0 → `preparacao` on the next edge → `espera_indice` one cycle later.
- Each of states 1, 3, 5, 7, 8, 9, 10 and 11 lasts exactly one cycle. All pulse outputs are therefore exactly one cycle wide.
- `registraM` fires one cycle after `indiceReady` is seen, so the index generator must hold `perm` valid for at least that cycle.
- Play path, from the `jogada_feita` edge: 7 → 8 → 10 → 11, which is 4 cycles to the next `espera_indice` or to `fim`.
- Timeout path: `timeout_jogada` is asserted exactly `T_JOGADA` cycles after entry into state 6 (timer 0 … `T_JOGADA`-1). The loop then continues through 10 → 11.
- Simultaneous events in state 6: `jogada_feita` together with timer = `T_JOGADA`-1 → the play wins (state 7) and there is no timeout pulse.
- Game length: exactly 3 rounds. `contaRod` pulses 3 times, then `pronto`.
- `acertos` ends between 0 and 3.

## Test plan
- Reset mid-game:
  - Stimulus: drive the FSM to state 6, assert `reset` = 0 between clock edges.
  - Required: `db_estado` = 0 and all outputs 0 without waiting for a clock edge.
  - Required: after release with `iniciar` = 0, the FSM stays in state 0.
- Nominal all-correct game (`T_JOGADA` = 8, `botaoIgualMemoria` = 1, `jogada_feita` 3 cycles into state 6):
  - Required: 3 pulses each of `registraM`, `registraR`, `contaA` and `contaRod`.
  - Required: `pronto` = 1 in state 12.
  - Required: a datapath model shows `acertos` = 3.
- Play timeout (`T_JOGADA` = 8, no `jogada_feita`):
  - Required: `timeout_jogada` high exactly 8 cycles after entry into state 6.
  - Required: no `contaA` and no `registraR`.
  - Required: `contaRod` the next cycle.
- Simultaneous events: `jogada_feita` on the same cycle the timer reaches 7 → next state 7 and `timeout_jogada` stays 0.
- Ignored inputs:
  - `jogada_feita` pulsed during state 4 → no state change, no `registraR`.
  - `timeout_img` held 0 for 100 cycles → remains in state 4 with `contaimg` = 1.
- Restart from `fim`:
  - `iniciar` = 1 in state 12 → state 1 with all six `zera*` high for one cycle.
  - A wrong-answer game (`botaoIgualMemoria` = 0) then ends with `acertos` = 0.

Source files
------------

// File: rtl/unidade_controle_if.sv
`default_nettype none
// ============================================================================
// Module  : unidade_controle_if
// Purpose : control/status bundle between the MindFocus FSM and its datapath
// Revision: 1.0
// ============================================================================
interface unidade_controle_if;
  // datapath status towards the FSM
  logic       iniciar;
  logic       jogada_feita;
  logic       botaoIgualMemoria;
  logic       rodadaIgualFinal;
  logic       indiceReady;
  logic       timeout_img;
  // FSM commands towards the datapath
  logic       zeraA;
  logic       zeraRod;
  logic       zeraR;
  logic       zeraM;
  logic       zeraI;
  logic       zeraContImg;
  logic       registraR;
  logic       registraM;
  logic       contaRod;
  logic       contaA;
  logic       contaI;
  logic       contaimg;
  logic       pronto;
  logic       timeout_jogada;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada_feita, botaoIgualMemoria, rodadaIgualFinal,
           indiceReady, timeout_img,
    output zeraA, zeraRod, zeraR, zeraM, zeraI, zeraContImg, registraR,
           registraM, contaRod, contaA, contaI, contaimg, pronto,
           timeout_jogada, db_estado
  );

  modport slave (
    output iniciar, jogada_feita, botaoIgualMemoria, rodadaIgualFinal,
           indiceReady, timeout_img,
    input  zeraA, zeraRod, zeraR, zeraM, zeraI, zeraContImg, registraR,
           registraM, contaRod, contaA, contaI, contaimg, pronto,
           timeout_jogada, db_estado
  );
endinterface
`default_nettype wire

// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module  : unidade_controle
// Purpose : MindFocus round-loop FSM with an internal play-timeout timer
// Revision: 1.0
// ============================================================================
module unidade_controle #(
  parameter int T_JOGADA = 10000
) (
  input  wire logic          clock,
  input  wire logic          reset,
  unidade_controle_if.master bus
);

  localparam int            TW         = $clog2(T_JOGADA);
  localparam logic [TW-1:0] TIMER_LAST = TW'(T_JOGADA - 1);

  localparam logic [3:0] INICIAL         = 4'd0;
  localparam logic [3:0] PREPARACAO      = 4'd1;
  localparam logic [3:0] ESPERA_INDICE   = 4'd2;
  localparam logic [3:0] REGISTRA_INDICE = 4'd3;
  localparam logic [3:0] MOSTRA_IMAGEM   = 4'd4;
  localparam logic [3:0] INICIA_JOGADA   = 4'd5;
  localparam logic [3:0] ESPERA_JOGADA   = 4'd6;
  localparam logic [3:0] REGISTRA_JOGADA = 4'd7;
  localparam logic [3:0] COMPARA         = 4'd8;
  localparam logic [3:0] ESTOURO         = 4'd9;
  localparam logic [3:0] PROXIMA_RODADA  = 4'd10;
  localparam logic [3:0] VERIFICA_FIM    = 4'd11;
  localparam logic [3:0] FIM             = 4'd12;

  logic [3:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      INICIAL:         if (bus.iniciar) state_d = PREPARACAO;
      PREPARACAO:      state_d = ESPERA_INDICE;
      ESPERA_INDICE:   if (bus.indiceReady) state_d = REGISTRA_INDICE;
      REGISTRA_INDICE: state_d = MOSTRA_IMAGEM;
      MOSTRA_IMAGEM:   if (bus.timeout_img) state_d = INICIA_JOGADA;
      INICIA_JOGADA: begin
        timer_d = '0;
        state_d = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        // saturate so a play on the last timer cycle cannot wrap the count
        if (timer_q != TIMER_LAST) timer_d = timer_q + TW'(1);
        if (bus.jogada_feita)           state_d = REGISTRA_JOGADA;
        else if (timer_q == TIMER_LAST) state_d = ESTOURO;
      end
      REGISTRA_JOGADA: state_d = COMPARA;
      COMPARA:         state_d = PROXIMA_RODADA;
      ESTOURO:         state_d = PROXIMA_RODADA;
      PROXIMA_RODADA:  state_d = VERIFICA_FIM;
      VERIFICA_FIM:    state_d = bus.rodadaIgualFinal ? FIM : ESPERA_INDICE;
      FIM:             if (bus.iniciar) state_d = PREPARACAO;
      default:         state_d = INICIAL;
    endcase
  end

  always_comb begin
    bus.zeraA          = 1'b0;
    bus.zeraRod        = 1'b0;
    bus.zeraR          = 1'b0;
    bus.zeraM          = 1'b0;
    bus.zeraI          = 1'b0;
    bus.zeraContImg    = 1'b0;
    bus.registraR      = 1'b0;
    bus.registraM      = 1'b0;
    bus.contaRod       = 1'b0;
    bus.contaA         = 1'b0;
    bus.contaI         = 1'b0;
    bus.contaimg       = 1'b0;
    bus.pronto         = 1'b0;
    bus.timeout_jogada = 1'b0;
    case (state_q)
      PREPARACAO: begin
        bus.zeraA       = 1'b1;
        bus.zeraRod     = 1'b1;
        bus.zeraR       = 1'b1;
        bus.zeraM       = 1'b1;
        bus.zeraI       = 1'b1;
        bus.zeraContImg = 1'b1;
      end
      REGISTRA_INDICE: begin
        bus.registraM   = 1'b1;
        bus.zeraContImg = 1'b1;
      end
      MOSTRA_IMAGEM:   bus.contaimg = 1'b1;
      INICIA_JOGADA: begin
        bus.zeraI = 1'b1;
        bus.zeraR = 1'b1;
      end
      ESPERA_JOGADA:   bus.contaI         = 1'b1;
      REGISTRA_JOGADA: bus.registraR      = 1'b1;
      COMPARA:         bus.contaA         = bus.botaoIgualMemoria;
      ESTOURO:         bus.timeout_jogada = 1'b1;
      PROXIMA_RODADA:  bus.contaRod       = 1'b1;
      FIM:             bus.pronto         = 1'b1;
      default: ;
    endcase
  end

  assign bus.db_estado = state_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module  : tb_unidade_controle
// Purpose : randomized MindFocus games checked each cycle against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_unidade_controle;

  localparam int T_J = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  unidade_controle_if bus ();
  unidade_controle #(.T_JOGADA(T_J)) dut (.clock(clock), .reset(reset), .bus(bus));

  // output bit positions inside the packed comparison vector
  localparam logic [13:0] ZA = 14'h2000, ZROD = 14'h1000, ZR = 14'h0800, ZM = 14'h0400;
  localparam logic [13:0] ZI = 14'h0200, ZIMG = 14'h0100, RR = 14'h0080, RM = 14'h0040;
  localparam logic [13:0] CROD = 14'h0020, CA = 14'h0010, CI = 14'h0008, CIMG = 14'h0004;
  localparam logic [13:0] PR = 14'h0002, TJ = 14'h0001;

  logic [13:0] dut_out;
  assign dut_out = {bus.zeraA, bus.zeraRod, bus.zeraR, bus.zeraM, bus.zeraI, bus.zeraContImg,
                    bus.registraR, bus.registraM, bus.contaRod, bus.contaA, bus.contaI,
                    bus.contaimg, bus.pronto, bus.timeout_jogada};

  // datapath model: score, round counter and pulse tallies driven by the FSM commands
  int dp_acertos, dp_rodada, n_regM, n_regR, n_contaA, n_contaRod, cyc;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.zeraA) dp_acertos <= 0;
    else if (bus.contaA) dp_acertos <= dp_acertos + 1;
    if (bus.zeraRod) dp_rodada <= 0;
    else if (bus.contaRod) dp_rodada <= dp_rodada + 1;
    n_regM     <= n_regM + int'(bus.registraM);
    n_regR     <= n_regR + int'(bus.registraR);
    n_contaA   <= n_contaA + int'(bus.contaA);
    n_contaRod <= n_contaRod + int'(bus.contaRod);
  end
  assign bus.rodadaIgualFinal = (dp_rodada == 3);

  // behavioural reference: game phase plus cycles spent waiting for the play
  function automatic int ref_next(input int s, input int waited, input logic ini,
                                  input logic jf, input logic idx, input logic img,
                                  input logic fin);
    if (s == 0 || s == 12) return ini ? 1 : s;
    if (s == 1 || s == 3 || s == 5 || s == 7 || s == 10) return s + 1;
    if (s == 2) return idx ? 3 : 2;
    if (s == 4) return img ? 5 : 4;
    if (s == 6) begin
      if (jf) return 7;
      return (waited + 1 == T_J) ? 9 : 6;
    end
    if (s == 8 || s == 9) return 10;
    if (s == 11) return fin ? 12 : 2;
    return 0;
  endfunction

  function automatic logic [13:0] ref_out(input int s, input logic hit);
    case (s)
      1:       return ZA | ZROD | ZR | ZM | ZI | ZIMG;
      3:       return RM | ZIMG;
      4:       return CIMG;
      5:       return ZI | ZR;
      6:       return CI;
      7:       return RR;
      8:       return hit ? CA : 14'h0;
      9:       return TJ;
      10:      return CROD;
      12:      return PR;
      default: return 14'h0;
    endcase
  endfunction

  int m_state, m_wait;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state <= 0;
      m_wait  <= 0;
    end else begin
      m_state <= ref_next(m_state, m_wait, bus.iniciar, bus.jogada_feita, bus.indiceReady,
                          bus.timeout_img, bus.rodadaIgualFinal);
      if (m_state == 5)      m_wait <= 0;
      else if (m_state == 6) m_wait <= m_wait + 1;
    end
  end

  int   n_pass, n_total;
  logic chk_en, img_hold, ini_rand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (ini_rand) bus.iniciar = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (bus.db_estado !== s && n < budget) begin
      step();
      n++;
    end
    if (bus.db_estado !== s) begin
      n_total++;
      $display("FAIL wait_state: state %0d after %0d cycles, required %0d", bus.db_estado, n, s);
    end
  endtask

  task automatic restart();
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
  endtask

  // delay < 0 lets the play time out; otherwise jogada_feita fires after delay cycles in state 6
  task automatic run_round(input int delay, input logic hit, input logic rnd_ini);
    ini_rand = rnd_ini;
    wait_state(4'd6, 400);
    bus.botaoIgualMemoria = hit;
    if (delay >= 0) begin
      repeat (delay) step();
      bus.jogada_feita = 1'b1;
      step();
      bus.jogada_feita = 1'b0;
    end
    wait_state(4'd11, 40);
    ini_rand    = 1'b0;
    bus.iniciar = 1'b0;
  endtask

  initial begin
    bus.iniciar = 1'b0; bus.jogada_feita = 1'b0; bus.botaoIgualMemoria = 1'b0;
    bus.indiceReady = 1'b0; bus.timeout_img = 1'b0;
    chk_en = 1'b0; img_hold = 1'b0; ini_rand = 1'b0;
    n_pass = 0; n_total = 0;
    fork
      forever begin
        @(negedge clock);
        if (chk_en) begin
          check("state_vs_model", 32'(bus.db_estado), 32'(m_state));
          check("outputs_vs_model", 32'(dut_out), 32'(ref_out(m_state, bus.botaoIgualMemoria)));
        end
      end
      forever begin
        @(posedge clock);
        #2;
        bus.indiceReady = ($urandom_range(0, 2) == 0);
        bus.timeout_img = img_hold ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
      begin : main_seq
        int rr, ca, rm, crod, t0, exp_hits, d;
        logic hit;
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();
        check("reset_state", 32'(bus.db_estado), 32'd0);
        check("reset_outputs", 32'(dut_out), 32'd0);
        reset = 1'b1;
        step();
        check("idle_after_reset", 32'(bus.db_estado), 32'd0);

        // nominal all-correct game
        rm = n_regM; rr = n_regR; ca = n_contaA; crod = n_contaRod;
        restart();
        for (int r = 0; r < 3; r++) run_round(2, 1'b1, 1'b0);
        wait_state(4'd12, 20);
        check("nominal_pronto", 32'(bus.pronto), 32'd1);
        check("nominal_acertos", dp_acertos, 32'd3);
        check("nominal_registraM", n_regM - rm, 32'd3);
        check("nominal_registraR", n_regR - rr, 32'd3);
        check("nominal_contaA", n_contaA - ca, 32'd3);
        check("nominal_contaRod", n_contaRod - crod, 32'd3);

        // restart from fim, then a wrong-answer game
        restart();
        check("restart_state", 32'(bus.db_estado), 32'd1);
        check("restart_zera", 32'(dut_out[13:8]), 32'h3f);
        for (int r = 0; r < 3; r++) begin
          d = $urandom_range(0, 9);
          run_round((d > 7) ? -1 : d, 1'b0, 1'b0);
        end
        wait_state(4'd12, 20);
        check("wrong_acertos", dp_acertos, 32'd0);

        // directed game: timeout, simultaneous events, ignored inputs
        restart();
        bus.botaoIgualMemoria = 1'b1;
        wait_state(4'd6, 400);
        t0 = cyc; rr = n_regR; ca = n_contaA;
        wait_state(4'd9, 20);
        check("timeout_latency", cyc - t0, 32'd8);
        check("timeout_pulse", 32'(bus.timeout_jogada), 32'd1);
        step();
        check("timeout_contaRod", 32'(bus.contaRod), 32'd1);
        check("timeout_no_registraR", n_regR - rr, 32'd0);
        check("timeout_no_contaA", n_contaA - ca, 32'd0);
        wait_state(4'd11, 10);

        wait_state(4'd6, 400);
        repeat (7) step();
        bus.jogada_feita = 1'b1;
        step();
        bus.jogada_feita = 1'b0;
        check("simul_state", 32'(bus.db_estado), 32'd7);
        check("simul_no_timeout", 32'(bus.timeout_jogada), 32'd0);
        wait_state(4'd11, 10);

        img_hold = 1'b1;
        wait_state(4'd4, 400);
        rr = n_regR;
        bus.jogada_feita = 1'b1;
        step();
        bus.jogada_feita = 1'b0;
        check("jf_ignored_state", 32'(bus.db_estado), 32'd4);
        repeat (100) step();
        check("img_hold_state", 32'(bus.db_estado), 32'd4);
        check("img_hold_contaimg", 32'(bus.contaimg), 32'd1);
        check("jf_ignored_registraR", n_regR - rr, 32'd0);
        img_hold = 1'b0;
        run_round(3, 1'b1, 1'b0);
        wait_state(4'd12, 20);
        check("directed_acertos", dp_acertos, 32'd2);

        // asynchronous reset while waiting for a play
        restart();
        wait_state(4'd6, 400);
        #2 reset = 1'b0;
        #1;
        check("async_reset_state", 32'(bus.db_estado), 32'd0);
        check("async_reset_outputs", 32'(dut_out), 32'd0);
        step();
        reset = 1'b1;
        repeat (5) step();
        check("post_reset_idle", 32'(bus.db_estado), 32'd0);

        // randomized games
        for (int g = 0; g < 6; g++) begin
          exp_hits = 0;
          restart();
          for (int r = 0; r < 3; r++) begin
            d   = $urandom_range(0, 9);
            hit = 1'($urandom_range(0, 1));
            if (d <= 7 && hit) exp_hits++;
            run_round((d > 7) ? -1 : d, hit, 1'b1);
          end
          wait_state(4'd12, 20);
          check("random_acertos", dp_acertos, exp_hits);
        end
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    join_any
  end

endmodule
`default_nettype wire
